// File: rtl/bram_a_pkg.sv
// Shared constants and state encoding for the BRAM_Memory_A stream controller.
//   BRAM_DATA_W : word width of the BRAM data ports
//   BRAM_ADDR_W : BRAM address width
//   BRAM_DEPTH  : maximum number of words held in one frame
//   state_t     : controller state encoding
package bram_a_pkg;

  localparam int BRAM_DATA_W = 32;
  localparam int BRAM_ADDR_W = 5;
  localparam int BRAM_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/bram_a_skid_fifo.sv
// Small first-word-fall-through FIFO that absorbs BRAM read data while the
// output stream is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : word to store
//   pop        : consume the head word (ignored when empty)
//   pop_data   : head word, valid whenever empty is low
//   occ        : number of stored words
//   empty/full : occupancy flags
module bram_a_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [OCC_W-1:0] occ,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (occ_reg == '0);
  assign full     = (occ_reg == OCC_W'(DEPTH));
  assign occ      = occ_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage needs no reset: the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/bram_a_stream_ctrl.sv
// Frame buffer controller in front of BRAM_Memory_A. An input stream is
// written to consecutive addresses from 0 (FILL), held (HOLD), and on
// rd_start read back in order as an output stream with a last marker (DRAIN).
//   clk, rst_n                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last : input stream
//   rd_start                   : one-cycle drain request, honoured in HOLD only
//   m_valid/m_ready/m_data/m_last : output stream
//   busy                       : high in FILL, HOLD or DRAIN
//   frame_len                  : number of words in the stored frame
//   bram_en/we/addr/din, bram_dout : single BRAM port
module bram_a_stream_ctrl
  import bram_a_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W,
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DEPTH  = BRAM_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              rd_start,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [ADDR_W:0]   frame_len,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int FIFO_D = RD_LAT + 1;
  localparam int OCC_W  = $clog2(FIFO_D + 1);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int CR_W   = OCC_W + 2;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  frame_len_reg, frame_len_next;
  logic              s_ready_reg;
  logic [RD_LAT-1:0] vld_pipe_reg;
  logic [RD_LAT-1:0] last_pipe_reg;

  logic              wr_fire;
  logic              word_last;
  logic              rd_issue;
  logic              issue_last;
  logic              pop;
  logic              push;
  logic [CR_W-1:0]   inflight_cnt;
  logic [CR_W-1:0]   credit_used;
  logic [DATA_W:0]   fifo_dout;
  logic [OCC_W-1:0]  fifo_occ;
  logic              fifo_empty;
  logic              fifo_full;

  // s_ready is registered from the next state, so it stays low while reset
  // is held and rises one cycle after release.
  assign wr_fire    = s_valid && s_ready_reg;
  // The DEPTH-th word closes the frame whatever s_last says.
  assign word_last  = s_last || (wr_ptr_reg == ADDR_W'(DEPTH - 1));
  assign pop        = m_valid && m_ready;
  assign push       = vld_pipe_reg[RD_LAT-1];
  assign issue_last = (rd_ptr_reg == frame_len_reg - CNT_W'(1));

  // Reads in flight plus words already buffered must never exceed the FIFO
  // depth; a word leaving this cycle frees its slot immediately.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CR_W'(vld_pipe_reg[i]);
    end
    credit_used = inflight_cnt + CR_W'(fifo_occ) - CR_W'(pop);
  end

  // The full term is implied by the credit check; kept as a direct guard.
  assign rd_issue = (state_reg == DRAIN) && (rd_ptr_reg < frame_len_reg) &&
                    (credit_used < CR_W'(FIFO_D)) && (!fifo_full || pop);

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    frame_len_next = frame_len_reg;
    case (state_reg)
      IDLE, FILL: begin
        if (wr_fire) begin
          frame_len_next = CNT_W'(wr_ptr_reg) + CNT_W'(1);
          if (word_last) begin
            state_next  = HOLD;
            wr_ptr_next = '0;
          end else begin
            state_next  = FILL;
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
        end
      end
      HOLD: begin
        rd_ptr_next = '0;
        if (rd_start) state_next = DRAIN;
      end
      DRAIN: begin
        if (rd_issue) rd_ptr_next = rd_ptr_reg + CNT_W'(1);
        if (pop && m_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      frame_len_reg <= '0;
      s_ready_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      frame_len_reg <= frame_len_next;
      s_ready_reg   <= (state_next == IDLE) || (state_next == FILL);
    end
  end

  // Tracks each issued read (and whether it is the frame's last word) until
  // its data appears on bram_dout RD_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_reg  <= '0;
      last_pipe_reg <= '0;
    end else begin
      vld_pipe_reg[0]  <= rd_issue;
      last_pipe_reg[0] <= rd_issue && issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
        last_pipe_reg[i] <= last_pipe_reg[i-1];
      end
    end
  end

  bram_a_skid_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({last_pipe_reg[RD_LAT-1], bram_dout}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .occ       (fifo_occ),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign s_ready   = s_ready_reg;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign m_last    = fifo_empty ? 1'b0 : fifo_dout[DATA_W];
  assign busy      = (state_reg != IDLE);
  assign frame_len = frame_len_reg;

  assign bram_en   = wr_fire || rd_issue;
  assign bram_we   = wr_fire;
  assign bram_addr = wr_fire ? wr_ptr_reg : rd_ptr_reg[ADDR_W-1:0];
  assign bram_din  = wr_fire ? s_data : '0;

endmodule

// File: tb/tb_bram_a_stream_ctrl.sv
// Two controllers share all stimulus: one with RD_LAT=1, one with RD_LAT=2,
// each with its own behavioural BRAM of matching read latency.
module tb_bram_a_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        rd_start = 1'b0;
  logic        m_ready = 1'b0;

  logic        s_ready_1, m_valid_1, m_last_1, busy_1, bram_en_1, bram_we_1;
  logic [31:0] m_data_1, bram_din_1, bram_dout_1;
  logic [5:0]  frame_len_1;
  logic [4:0]  bram_addr_1;
  logic        s_ready_2, m_valid_2, m_last_2, busy_2, bram_en_2, bram_we_2;
  logic [31:0] m_data_2, bram_din_2, bram_dout_2;
  logic [5:0]  frame_len_2;
  logic [4:0]  bram_addr_2;

  always #5 clk = ~clk;

  bram_a_stream_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_1), .s_data(s_data),
    .s_last(s_last), .rd_start(rd_start), .m_valid(m_valid_1), .m_ready(m_ready),
    .m_data(m_data_1), .m_last(m_last_1), .busy(busy_1), .frame_len(frame_len_1),
    .bram_en(bram_en_1), .bram_we(bram_we_1), .bram_addr(bram_addr_1),
    .bram_din(bram_din_1), .bram_dout(bram_dout_1));

  bram_a_stream_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_2), .s_data(s_data),
    .s_last(s_last), .rd_start(rd_start), .m_valid(m_valid_2), .m_ready(m_ready),
    .m_data(m_data_2), .m_last(m_last_2), .busy(busy_2), .frame_len(frame_len_2),
    .bram_en(bram_en_2), .bram_we(bram_we_2), .bram_addr(bram_addr_2),
    .bram_din(bram_din_2), .bram_dout(bram_dout_2));

  // BRAM models: 1-cycle and 2-cycle read latency.
  logic [31:0] mem1 [32];
  logic [31:0] mem2 [32];
  logic [31:0] p1_1 = '0, p1_2 = '0, p2_2 = '0;
  always @(posedge clk) begin
    if (bram_en_1 && bram_we_1)  mem1[bram_addr_1] <= bram_din_1;
    if (bram_en_1 && !bram_we_1) p1_1 <= mem1[bram_addr_1];
    if (bram_en_2 && bram_we_2)  mem2[bram_addr_2] <= bram_din_2;
    if (bram_en_2 && !bram_we_2) p1_2 <= mem2[bram_addr_2];
    p2_2 <= p1_2;
  end
  assign bram_dout_1 = p1_1;
  assign bram_dout_2 = p2_2;

  // Monitor: collects writes, reads, output handshakes, latency, stalls.
  int          cyc_cnt = 0;
  int          rd_cnt_1 = 0, rd_cnt_2 = 0, vseen_1 = 0;
  int          stab_bad1 = 0, stab_bad2 = 0, occ_max_1 = 0, occ_max_2 = 0;
  int          rd_cyc = 0, first_1 = 0, first_2 = 0;
  bit          got_1 = 1'b0, got_2 = 1'b0, st1 = 1'b0, st2 = 1'b0, pl1 = 1'b0, pl2 = 1'b0;
  logic [31:0] pd1 = '0, pd2 = '0;
  logic [4:0]  wa [$];
  logic [31:0] wd [$];
  logic [31:0] q1d [$];
  logic [31:0] q2d [$];
  bit          q1l [$];
  bit          q2l [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      st1 <= 1'b0;
      st2 <= 1'b0;
    end else begin
      if (bram_en_1 && bram_we_1) begin
        wa.push_back(bram_addr_1);
        wd.push_back(bram_din_1);
      end
      if (bram_en_1 && !bram_we_1) rd_cnt_1 <= rd_cnt_1 + 1;
      if (bram_en_2 && !bram_we_2) rd_cnt_2 <= rd_cnt_2 + 1;
      if (m_valid_1) vseen_1 <= vseen_1 + 1;
      if (rd_start) begin
        rd_cyc <= cyc_cnt;
        got_1  <= 1'b0;
        got_2  <= 1'b0;
      end else begin
        if (m_valid_1 && !got_1) begin first_1 <= cyc_cnt; got_1 <= 1'b1; end
        if (m_valid_2 && !got_2) begin first_2 <= cyc_cnt; got_2 <= 1'b1; end
      end
      if (st1 && !(m_valid_1 && m_data_1 == pd1 && m_last_1 == pl1)) stab_bad1 <= stab_bad1 + 1;
      if (st2 && !(m_valid_2 && m_data_2 == pd2 && m_last_2 == pl2)) stab_bad2 <= stab_bad2 + 1;
      st1 <= m_valid_1 && !m_ready;
      st2 <= m_valid_2 && !m_ready;
      pd1 <= m_data_1;  pl1 <= m_last_1;
      pd2 <= m_data_2;  pl2 <= m_last_2;
      if (m_valid_1 && m_ready) begin q1d.push_back(m_data_1); q1l.push_back(m_last_1); end
      if (m_valid_2 && m_ready) begin q2d.push_back(m_data_2); q2l.push_back(m_last_2); end
      if (int'(u_dut1.fifo_occ) > occ_max_1) occ_max_1 <= int'(u_dut1.fifo_occ);
      if (int'(u_dut2.fifo_occ) > occ_max_2) occ_max_2 <= int'(u_dut2.fifo_occ);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wdata(input logic [31:0] base, input int i);
    if (base == 32'h0 && i == 0) return 32'hFFFF_FFFF;
    return base + 32'(i);
  endfunction

  // Streams n_send words; rd_start is pulsed alongside word rd_pulse_at.
  task automatic fill_frame(input int n_send, input bit use_last, input logic [31:0] base,
                            input int exp_len, input int rd_pulse_at);
    int acc, w0, r1, v0, nw;
    bit got;
    @(negedge clk); #1;
    w0 = wa.size(); r1 = rd_cnt_1; v0 = vseen_1; acc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n_send; i++) begin
      s_valid  = 1'b1;
      s_data   = wdata(base, i);
      s_last   = use_last && (i == n_send - 1);
      rd_start = (i == rd_pulse_at);
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        @(negedge clk);
        got = s_ready_1;
        @(posedge clk); #1;
        rd_start = 1'b0;
      end
      if (got) acc++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    chk("words_accepted", acc, exp_len);
    @(negedge clk); #1;
    chk("frame_len_1", frame_len_1, exp_len);
    chk("frame_len_2", frame_len_2, exp_len);
    chk("busy_hold", busy_1, 1);
    chk("s_ready_hold", s_ready_1, 0);
    chk("no_reads_in_fill", rd_cnt_1 - r1, 0);
    chk("no_m_valid_in_fill", vseen_1 - v0, 0);
    nw = wa.size() - w0;
    chk("write_count", nw, exp_len);
    for (int i = 0; i < exp_len && i < nw; i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa[w0 + i], i);
      chk($sformatf("wr_data[%0d]", i), wd[w0 + i], wdata(base, i));
    end
  endtask

  task automatic drain_frame(input logic [31:0] base, input logic [3:0] stall, input int exp_len);
    int q1b, q2b, r1, r2, sb1, sb2, k, n1, n2;
    bit done;
    q1b = q1d.size(); q2b = q2d.size(); r1 = rd_cnt_1; r2 = rd_cnt_2;
    sb1 = stab_bad1; sb2 = stab_bad2;
    @(posedge clk); #1;
    rd_start = 1'b1; m_ready = stall[0];
    @(posedge clk); #1;
    rd_start = 1'b0;
    done = 1'b0; k = 1;
    for (int c = 0; c < 400 && !done; c++) begin
      m_ready = stall[k % 4];
      k++;
      @(negedge clk);
      done = !busy_1 && !busy_2;
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    chk("drain_done", done, 1);
    n1 = q1d.size() - q1b;
    n2 = q2d.size() - q2b;
    chk("out_count_1", n1, exp_len);
    chk("out_count_2", n2, exp_len);
    for (int i = 0; i < exp_len && i < n1; i++) begin
      chk($sformatf("m_data_1[%0d]", i), q1d[q1b + i], wdata(base, i));
      chk($sformatf("m_last_1[%0d]", i), q1l[q1b + i], (i == exp_len - 1));
    end
    for (int i = 0; i < exp_len && i < n2; i++) begin
      chk($sformatf("m_data_2[%0d]", i), q2d[q2b + i], wdata(base, i));
      chk($sformatf("m_last_2[%0d]", i), q2l[q2b + i], (i == exp_len - 1));
    end
    chk("latency_1", first_1 - rd_cyc, 3);
    chk("latency_2", first_2 - rd_cyc, 4);
    chk("reads_1", rd_cnt_1 - r1, exp_len);
    chk("reads_2", rd_cnt_2 - r2, exp_len);
    chk("stable_stall_1", stab_bad1 - sb1, 0);
    chk("stable_stall_2", stab_bad2 - sb2, 0);
    chk("frame_len_kept", frame_len_1, exp_len);
    chk("m_valid_idle", m_valid_1, 0);
    chk("s_ready_idle", s_ready_1, 1);
  endtask

  typedef struct {
    int          n_send;
    bit          use_last;
    logic [31:0] base;
    logic [3:0]  stall;
    int          exp_len;
    int          rd_pulse_at;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int r0, v0, q1b;
    bit seen;
    vecs[0] = '{20, 1'b1, 32'h0000_0000, 4'b1111, 20, -1};
    vecs[1] = '{33, 1'b0, 32'h1000_0000, 4'b1111, 32, -1};
    vecs[2] = '{12, 1'b1, 32'h2000_0000, 4'b1001, 12, -1};
    vecs[3] = '{6,  1'b1, 32'h3000_0000, 4'b0101, 6,  2};
    vecs[4] = '{1,  1'b1, 32'h4000_0000, 4'b1111, 1,  -1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready_1, 0);
    chk("rst_m_valid", m_valid_1, 0);
    chk("rst_m_data", m_data_1, 0);
    chk("rst_busy", busy_1, 0);
    chk("rst_frame_len", frame_len_1, 0);
    chk("rst_bram_en", bram_en_1, 0);
    chk("rst_state", longint'(u_dut1.state_reg), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // rd_start in IDLE must be ignored.
    @(negedge clk); #1;
    r0 = rd_cnt_1; v0 = vseen_1;
    @(posedge clk); #1; rd_start = 1'b1;
    @(posedge clk); #1; rd_start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    chk("idle_rd_start_reads", rd_cnt_1 - r0, 0);
    chk("idle_rd_start_valid", vseen_1 - v0, 0);
    chk("idle_rd_start_busy", busy_1, 0);

    for (int t = 0; t < 5; t++) begin
      fill_frame(vecs[t].n_send, vecs[t].use_last, vecs[t].base, vecs[t].exp_len, vecs[t].rd_pulse_at);
      drain_frame(vecs[t].base, vecs[t].stall, vecs[t].exp_len);
      $display("frame %0d: len=%0d stall=%b errors so far=%0d", t, vecs[t].exp_len, vecs[t].stall, errors);
    end

    // Asynchronous reset in the middle of a drain.
    fill_frame(10, 1'b1, 32'h5000_0000, 10, -1);
    q1b = q1d.size();
    @(posedge clk); #1; rd_start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1; rd_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #1;
      seen = (q1d.size() - q1b) >= 5;
    end
    chk("mid_drain_reached", seen, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid_1", m_valid_1, 0);
    chk("arst_m_valid_2", m_valid_2, 0);
    chk("arst_busy_1", busy_1, 0);
    chk("arst_busy_2", busy_2, 0);
    chk("arst_frame_len", frame_len_1, 0);
    chk("arst_bram_en", bram_en_1, 0);
    chk("arst_s_ready", s_ready_1, 0);
    chk("arst_state", longint'(u_dut1.state_reg), 0);
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_frame(4, 1'b1, 32'hC0DE_0000, 4, -1);
    drain_frame(32'hC0DE_0000, 4'b1111, 4);
    $display("post-reset frame: len=4 errors so far=%0d", errors);

    chk("fifo1_occ_bound", occ_max_1 <= 2, 1);
    chk("fifo2_occ_bound", occ_max_2 <= 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
